rf_write_arbiter: RTL

Write-port controller for the 32 x 64-bit integer register file. It shares the file's single write port between the ALU writeback source and the load writeback source using a valid/ready handshake and round-robin arbitration. After reset it can sweep the file to its defined initial contents. It sits between the execute/memory stages and the register file's write inputs; read ports are untouched.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_arb2.sv | 36 +++
 rtl/rf_write_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register-file write path.
package rf_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam int REQ_LD  = 0;
  localparam int REQ_ALU = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The registered pointer holds the index that
// was granted most recently; it only moves when upd_en_i is high.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      if (last_q == 1'(REQ_ALU)) gnt_o[REQ_LD]  = 1'b1;
      else                       gnt_o[REQ_ALU] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd_en_i && (gnt_o != 2'b00)) last_d = gnt_o[REQ_ALU];
  end

  // Pointer starts on ALU so the first contended grant goes to the load side.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'(REQ_ALU);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between ALU and load writeback.
// Define RF_INIT_SWEEP_EN to add the post-reset sweep writing x[i] = i.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic            active;
  logic            sweep_we;
  logic [AW-1:0]   sweep_idx;
  logic            alu_x0, ld_x0, alu_nz, ld_nz;
  logic [1:0]      req, gnt;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef RF_INIT_SWEEP_EN
  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(NREGS - 1)) state_d = RUN;
    end
  end

  assign sweep_we  = (state_q == INIT);
  assign sweep_idx = idx_q;
  assign busy      = (state_q == INIT);
  assign active    = (state_q == RUN) && !reset;
`else
  assign sweep_we  = 1'b0;
  assign sweep_idx = '0;
  assign busy      = 1'b0;
  assign active    = !reset;
`endif

  // x0 targets are acknowledged but never reach the arbiter or the write port.
  assign alu_x0 = alu_valid && (alu_rd == '0);
  assign ld_x0  = ld_valid  && (ld_rd  == '0);
  assign alu_nz = alu_valid && (alu_rd != '0);
  assign ld_nz  = ld_valid  && (ld_rd  != '0);

  assign req[REQ_LD]  = ld_nz  && active;
  assign req[REQ_ALU] = alu_nz && active;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .upd_en_i (active),
    .gnt_o    (gnt)
  );

  assign alu_ready = active && (alu_x0 || gnt[REQ_ALU]);
  assign ld_ready  = active && (ld_x0  || gnt[REQ_LD]);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (sweep_we) begin
      we_d    = 1'b1;
      waddr_d = sweep_idx;
      wdata_d = XLEN'(sweep_idx);
    end else if (gnt[REQ_LD]) begin
      we_d    = 1'b1;
      waddr_d = ld_rd;
      wdata_d = ld_data;
    end else if (gnt[REQ_ALU]) begin
      we_d    = 1'b1;
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end
    if (active && alu_nz && ld_nz && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule
